// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus unit.
// Holds the access-size encodings, FSM state encodings, fault codes and the
// alignment check used when a request is accepted.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10,
    ST_FAULT  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_TIMEOUT  = 2'b10,
    FC_ILLSIZE  = 2'b11
  } fcode_e;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_bus_unit_if.sv
// Bus bundle for the memory bus unit.
// Carries the core-side request/done handshake and the external RAM strobes.
//   slave  : view of the memory bus unit (takes requests, drives the RAM)
//   master : view of the environment (core issuing requests plus RAM model)
interface mem_bus_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // core side
  logic              req;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              fault;
  logic [1:0]        fault_code;
  // RAM side
  logic              ram_cs;
  logic              ram_we;
  logic              ram_oe;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;

  modport slave (
    input  req, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata, ram_ready,
    output busy, done, rdata, fault, fault_code,
           ram_cs, ram_we, ram_oe, ram_addr, ram_be, ram_wdata
  );

  modport master (
    output req, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata, ram_ready,
    input  busy, done, rdata, fault, fault_code,
           ram_cs, ram_we, ram_oe, ram_addr, ram_be, ram_wdata
  );
endinterface

// File: rtl/mbu_lane_align.sv
// Byte-lane steering for the memory bus unit (purely combinational).
//   st_size/st_addr_lo/st_wdata -> st_be, st_wdata_rep : store lane enables and
//                                  replicated store data
//   ld_size/ld_addr_lo/ld_signed/ld_word -> ld_data    : extracted and
//                                  sign/zero-extended load value
module mbu_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store path: lane enables and data replicated across every lane it may hit.
  always_comb begin
    st_be        = 4'b0000;
    st_wdata_rep = 32'h0000_0000;
    case (st_size)
      SZ_BYTE: begin
        st_be        = 4'b0001 << st_addr_lo;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be        = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      SZ_WORD: begin
        st_be        = 4'b1111;
        st_wdata_rep = st_wdata;
      end
      default: begin
        st_be        = 4'b0000;
        st_wdata_rep = 32'h0000_0000;
      end
    endcase
  end

  // Load path: pick the addressed lane, then extend to a full word.
  always_comb begin
    case (ld_addr_lo)
      2'b00:   byte_s = ld_word[7:0];
      2'b01:   byte_s = ld_word[15:8];
      2'b10:   byte_s = ld_word[23:16];
      2'b11:   byte_s = ld_word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (ld_addr_lo[1]) begin
      half_s = ld_word[31:16];
    end else begin
      half_s = ld_word[15:0];
    end
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & byte_s[7]}}, byte_s};
      SZ_HALF: ld_data = {{16{ld_signed & half_s[15]}}, half_s};
      SZ_WORD: ld_data = ld_word;
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_bus_unit.sv
// Memory bus unit: sequences one load/store between the core and external RAM.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_bus_unit_if.slave -- request/done handshake (req*, busy, done,
//          rdata, fault, fault_code) and RAM strobes (ram_*)
// Requests are checked for size/alignment on acceptance; bad ones fault
// without ever touching the RAM. Good ones hold the RAM strobes until
// ram_ready, with an optional wait-state timeout.
module mem_bus_unit
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  mem_bus_unit_if.slave bus
);

  localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mem_bus_unit: DATA_W must be 32");
  end
  if (ADDR_W < 3) begin : g_bad_addr_w
    $error("mem_bus_unit: ADDR_W must be at least 3");
  end

  state_e            state_r, state_nx;
  logic [CNT_W-1:0]  cnt_r, cnt_nx, cnt_inc_s;
  logic [1:0]        addr_lo_r, addr_lo_nx, size_r, size_nx, fcode_r, fcode_nx;
  logic              we_r, we_nx, sgn_r, sgn_nx;
  logic              busy_r, busy_nx, done_r, done_nx, fault_r, fault_nx;
  logic [DATA_W-1:0] rdata_r, rdata_nx, ram_wdata_r, ram_wdata_nx;
  logic              ram_cs_r, ram_cs_nx, ram_we_r, ram_we_nx, ram_oe_r, ram_oe_nx;
  logic [ADDR_W-1:0] ram_addr_r, ram_addr_nx;
  logic [3:0]        ram_be_r, ram_be_nx, st_be_s;
  logic [31:0]       st_wdata_s, ld_data_s;

  // Store lanes come straight from the request (captured on acceptance);
  // load extraction uses the latched request and the live RAM word.
  mbu_lane_align u_lane (
    .st_size      (bus.req_size),
    .st_addr_lo   (bus.req_addr[1:0]),
    .st_wdata     (bus.req_wdata),
    .st_be        (st_be_s),
    .st_wdata_rep (st_wdata_s),
    .ld_size      (size_r),
    .ld_addr_lo   (addr_lo_r),
    .ld_signed    (sgn_r),
    .ld_word      (bus.ram_rdata),
    .ld_data      (ld_data_s)
  );

  // Next-state and next-output logic; RAM strobes are only ever set up on
  // entry to ACCESS, so fault paths leave them low.
  always_comb begin
    state_nx     = state_r;
    cnt_nx       = cnt_r;
    addr_lo_nx   = addr_lo_r;
    size_nx      = size_r;
    we_nx        = we_r;
    sgn_nx       = sgn_r;
    rdata_nx     = rdata_r;
    fcode_nx     = fcode_r;
    done_nx      = 1'b0;
    fault_nx     = 1'b0;
    ram_cs_nx    = 1'b0;
    ram_we_nx    = 1'b0;
    ram_oe_nx    = 1'b0;
    ram_addr_nx  = {ADDR_W{1'b0}};
    ram_be_nx    = 4'b0000;
    ram_wdata_nx = {DATA_W{1'b0}};
    if (cnt_r == CNT_MAX) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end
    case (state_r)
      ST_IDLE: begin
        if (bus.req) begin
          addr_lo_nx = bus.req_addr[1:0];
          size_nx    = bus.req_size;
          we_nx      = bus.req_we;
          sgn_nx     = bus.req_signed;
          if (bus.req_size == SZ_ILL) begin
            state_nx = ST_FAULT;
            done_nx  = 1'b1;
            fault_nx = 1'b1;
            fcode_nx = FC_ILLSIZE;
          end else if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            state_nx = ST_FAULT;
            done_nx  = 1'b1;
            fault_nx = 1'b1;
            fcode_nx = FC_MISALIGN;
          end else begin
            state_nx     = ST_ACCESS;
            cnt_nx       = {CNT_W{1'b0}};
            ram_cs_nx    = 1'b1;
            ram_we_nx    = bus.req_we;
            ram_oe_nx    = ~bus.req_we;
            ram_addr_nx  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            ram_be_nx    = st_be_s;
            ram_wdata_nx = st_wdata_s;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (bus.ram_ready) begin
          state_nx = ST_DONE;
          done_nx  = 1'b1;
          fcode_nx = FC_NONE;
          if (!we_r) begin
            rdata_nx = ld_data_s;
          end else begin
            rdata_nx = rdata_r;
          end
        end else begin
          cnt_nx = cnt_inc_s;
          if (TO_EN && (cnt_inc_s >= CNT_TO)) begin
            state_nx = ST_FAULT;
            done_nx  = 1'b1;
            fault_nx = 1'b1;
            fcode_nx = FC_TIMEOUT;
          end else begin
            ram_cs_nx    = ram_cs_r;
            ram_we_nx    = ram_we_r;
            ram_oe_nx    = ram_oe_r;
            ram_addr_nx  = ram_addr_r;
            ram_be_nx    = ram_be_r;
            ram_wdata_nx = ram_wdata_r;
          end
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      ST_FAULT: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Latched request, wait counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= {CNT_W{1'b0}};
      addr_lo_r   <= 2'b00;
      size_r      <= 2'b00;
      we_r        <= 1'b0;
      sgn_r       <= 1'b0;
      rdata_r     <= {DATA_W{1'b0}};
      fcode_r     <= 2'b00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      ram_cs_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_oe_r    <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_be_r    <= 4'b0000;
      ram_wdata_r <= {DATA_W{1'b0}};
    end else begin
      cnt_r       <= cnt_nx;
      addr_lo_r   <= addr_lo_nx;
      size_r      <= size_nx;
      we_r        <= we_nx;
      sgn_r       <= sgn_nx;
      rdata_r     <= rdata_nx;
      fcode_r     <= fcode_nx;
      busy_r      <= busy_nx;
      done_r      <= done_nx;
      fault_r     <= fault_nx;
      ram_cs_r    <= ram_cs_nx;
      ram_we_r    <= ram_we_nx;
      ram_oe_r    <= ram_oe_nx;
      ram_addr_r  <= ram_addr_nx;
      ram_be_r    <= ram_be_nx;
      ram_wdata_r <= ram_wdata_nx;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.rdata      = rdata_r;
  assign bus.fault      = fault_r;
  assign bus.fault_code = fcode_r;
  assign bus.ram_cs     = ram_cs_r;
  assign bus.ram_we     = ram_we_r;
  assign bus.ram_oe     = ram_oe_r;
  assign bus.ram_addr   = ram_addr_r;
  assign bus.ram_be     = ram_be_r;
  assign bus.ram_wdata  = ram_wdata_r;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Scoreboard bench for mem_bus_unit: dut_a uses TIMEOUT=4, dut_b TIMEOUT=0.
module tb_mem_bus_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   vec = 0;
  int   errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic        fault;
    logic [1:0]  code;
    logic [31:0] rdata;
    int          lat;
    int          k;
  } exp_t;

  typedef struct {
    logic        we;
    logic        oe;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ram_t;

  exp_t exp_q[$];
  exp_t expb_q[$];
  ram_t ram_q[$];
  exp_t me, mb;
  ram_t mr;
  int   wait_a = 0, wait_b = 0, acc_a = 0, acc_b = 0;
  logic cs_prev = 1'b0;

  mem_bus_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_bus_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  mem_bus_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_bus_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    vec++;
    errs++;
    $display("FAIL %s: event with empty scoreboard (t=%0t)", name, $time);
  endtask

  function automatic exp_t mk_e(input logic f, input logic [1:0] c, input logic [31:0] d, input int l);
    exp_t e;
    e.fault = f; e.code = c; e.rdata = d; e.lat = l; e.k = 0;
    return e;
  endfunction

  function automatic ram_t mk_r(input logic we, input logic [3:0] be, input logic [31:0] ad, input logic [31:0] wd);
    ram_t r;
    r.we = we; r.oe = ~we; r.addr = ad; r.be = be; r.wdata = wd;
    return r;
  endfunction

  // RAM models: ready after the configured number of wait cycles in ACCESS.
  always @(negedge clk) begin
    if (bus_a.ram_cs) begin
      bus_a.ram_ready = (acc_a == wait_a);
      acc_a++;
    end else begin
      bus_a.ram_ready = 1'b0;
      acc_a = 0;
    end
    if (bus_b.ram_cs) begin
      bus_b.ram_ready = (acc_b == wait_b);
      acc_b++;
    end else begin
      bus_b.ram_ready = 1'b0;
      acc_b = 0;
    end
  end

  // Monitor for dut_a: RAM strobes on each access start, response on done.
  always @(negedge clk) begin
    if (!rst) begin
      cs_prev = 1'b0;
    end else begin
      if (bus_a.ram_cs && !cs_prev) begin
        if (ram_q.size() == 0) begin
          unexpected("ram_cs_rise");
        end else begin
          mr = ram_q.pop_front();
          chk("ram_we", bus_a.ram_we, mr.we);
          chk("ram_oe", bus_a.ram_oe, mr.oe);
          chk("ram_be", bus_a.ram_be, mr.be);
          chk("ram_addr", bus_a.ram_addr, mr.addr);
          chk("ram_wdata", bus_a.ram_wdata, mr.wdata);
        end
      end
      cs_prev = bus_a.ram_cs;
      if (bus_a.done) begin
        if (exp_q.size() == 0) begin
          unexpected("done_a");
        end else begin
          me = exp_q.pop_front();
          chk("fault", bus_a.fault, me.fault);
          chk("fault_code", bus_a.fault_code, me.code);
          chk("rdata", bus_a.rdata, me.rdata);
          chk("latency", edge_cnt - me.k + 1, me.lat);
          chk("busy_at_done", bus_a.busy, 1'b1);
          chk("ram_cs_at_done", bus_a.ram_cs, 1'b0);
        end
      end
    end
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (rst && bus_b.done) begin
      if (expb_q.size() == 0) begin
        unexpected("done_b");
      end else begin
        mb = expb_q.pop_front();
        chk("b_fault", bus_b.fault, mb.fault);
        chk("b_rdata", bus_b.rdata, mb.rdata);
        chk("b_latency", edge_cnt - mb.k + 1, mb.lat);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                       input logic [31:0] wd, input exp_t e, input bit has_ram, input ram_t r);
    @(negedge clk);
    bus_a.req = 1'b1; bus_a.req_we = we; bus_a.req_size = sz;
    bus_a.req_signed = sg; bus_a.req_addr = ad; bus_a.req_wdata = wd;
    @(posedge clk);
    #1;
    e.k = edge_cnt;
    exp_q.push_back(e);
    if (has_ram) ram_q.push_back(r);
    @(negedge clk);
    bus_a.req = 1'b0;
  endtask

  task automatic drain(input bit b, input int lim);
    int n = 0;
    while (((b ? expb_q.size() : exp_q.size()) != 0) && (n < lim)) begin
      @(negedge clk);
      n++;
    end
    if ((b ? expb_q.size() : exp_q.size()) != 0) begin
      vec++;
      errs++;
      $display("FAIL drain_timeout: no done within %0d cycles (dut %s)", lim, b ? "b" : "a");
      exp_q.delete();
      expb_q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, bus_a.busy, 1'b0);
    chk({tag, "_done"}, bus_a.done, 1'b0);
    chk({tag, "_rdata"}, bus_a.rdata, 32'h0);
    chk({tag, "_fault"}, bus_a.fault, 1'b0);
    chk({tag, "_fault_code"}, bus_a.fault_code, 2'b00);
    chk({tag, "_ram_ctl"}, {bus_a.ram_cs, bus_a.ram_we, bus_a.ram_oe, bus_a.ram_be}, 7'h00);
    chk({tag, "_ram_addr"}, bus_a.ram_addr, 32'h0);
    chk({tag, "_ram_wdata"}, bus_a.ram_wdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.req = 1'b0; bus_a.req_we = 1'b0; bus_a.req_size = 2'b00; bus_a.req_signed = 1'b0;
    bus_a.req_addr = 32'h0; bus_a.req_wdata = 32'h0; bus_a.ram_rdata = 32'h0;
    bus_b.req = 1'b0; bus_b.req_we = 1'b0; bus_b.req_size = 2'b00; bus_b.req_signed = 1'b0;
    bus_b.req_addr = 32'h0; bus_b.req_wdata = 32'h0; bus_b.ram_rdata = 32'h0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    chk("b_reset_busy", bus_b.busy, 1'b0);
    rst = 1'b1;

    // signed byte load from lane 3
    bus_a.ram_rdata = 32'h80FF_1234;
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, mk_e(1'b0, 2'b00, 32'hFFFF_FF80, 2), 1'b1,
          mk_r(1'b0, 4'b1000, 32'h100, 32'h0));
    drain(1'b0, 20);
    // half store to upper lanes, rdata keeps the previous load
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF, mk_e(1'b0, 2'b00, 32'hFFFF_FF80, 2), 1'b1,
          mk_r(1'b1, 4'b1100, 32'h200, 32'hBEEF_BEEF));
    drain(1'b0, 20);
    // request-time faults: misaligned word, illegal size, misaligned half
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, mk_e(1'b1, 2'b01, 32'hFFFF_FF80, 1), 1'b0, mk_r(1'b0, 4'b0, 32'h0, 32'h0));
    drain(1'b0, 20);
    issue(1'b1, 2'b11, 1'b0, 32'h001, 32'h0, mk_e(1'b1, 2'b11, 32'hFFFF_FF80, 1), 1'b0, mk_r(1'b0, 4'b0, 32'h0, 32'h0));
    drain(1'b0, 20);
    issue(1'b0, 2'b01, 1'b1, 32'h001, 32'h0, mk_e(1'b1, 2'b01, 32'hFFFF_FF80, 1), 1'b0, mk_r(1'b0, 4'b0, 32'h0, 32'h0));
    drain(1'b0, 20);
    @(negedge clk);
    chk("fault_code_held", bus_a.fault_code, 2'b01);
    chk("done_low_in_idle", bus_a.done, 1'b0);

    // timeout after 4 wait cycles
    wait_a = 1000;
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h1122_3344, mk_e(1'b1, 2'b10, 32'hFFFF_FF80, 5), 1'b1,
          mk_r(1'b0, 4'b1111, 32'h40, 32'h1122_3344));
    drain(1'b0, 30);

    // zero-extended half with 3 wait states, plus a req pulse while busy
    wait_a = 3;
    bus_a.ram_rdata = 32'h8001_0000;
    issue(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, mk_e(1'b0, 2'b00, 32'h0000_8001, 5), 1'b1,
          mk_r(1'b0, 4'b1100, 32'h04, 32'h0));
    @(negedge clk);
    bus_a.req = 1'b1; bus_a.req_size = 2'b11;
    @(negedge clk);
    bus_a.req = 1'b0;
    drain(1'b0, 30);

    // more extraction cases
    wait_a = 1;
    bus_a.ram_rdata = 32'h1234_F00D;
    issue(1'b0, 2'b01, 1'b1, 32'h00, 32'h0, mk_e(1'b0, 2'b00, 32'hFFFF_F00D, 3), 1'b1,
          mk_r(1'b0, 4'b0011, 32'h00, 32'h0));
    drain(1'b0, 20);
    wait_a = 0;
    bus_a.ram_rdata = 32'h0000_AB00;
    issue(1'b0, 2'b00, 1'b0, 32'h01, 32'h0, mk_e(1'b0, 2'b00, 32'h0000_00AB, 2), 1'b1,
          mk_r(1'b0, 4'b0010, 32'h00, 32'h0));
    drain(1'b0, 20);
    bus_a.ram_rdata = 32'h8000_0001;
    issue(1'b0, 2'b10, 1'b1, 32'h0C, 32'h0, mk_e(1'b0, 2'b00, 32'h8000_0001, 2), 1'b1,
          mk_r(1'b0, 4'b1111, 32'h0C, 32'h0));
    drain(1'b0, 20);
    issue(1'b1, 2'b00, 1'b1, 32'h02, 32'h0000_0055, mk_e(1'b0, 2'b00, 32'h8000_0001, 2), 1'b1,
          mk_r(1'b1, 4'b0100, 32'h00, 32'h5555_5555));
    drain(1'b0, 20);
    issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, mk_e(1'b0, 2'b00, 32'h8000_0001, 2), 1'b1,
          mk_r(1'b1, 4'b1111, 32'h08, 32'hDEAD_BEEF));
    drain(1'b0, 20);

    // reset in the middle of an access
    wait_a = 20;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, mk_e(1'b0, 2'b00, 32'h0, 2), 1'b1,
          mk_r(1'b0, 4'b1111, 32'h10, 32'h0));
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_zero("mid_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    wait_a = 0;
    bus_a.ram_rdata = 32'h7F00_0000;
    issue(1'b0, 2'b00, 1'b0, 32'h03, 32'h0, mk_e(1'b0, 2'b00, 32'h0000_007F, 2), 1'b1,
          mk_r(1'b0, 4'b1000, 32'h00, 32'h0));
    drain(1'b0, 20);

    // timeout disabled: 50 wait cycles complete normally
    wait_b = 50;
    bus_b.ram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_b.req = 1'b1; bus_b.req_size = 2'b10; bus_b.req_addr = 32'h20;
    @(posedge clk);
    #1;
    mb = mk_e(1'b0, 2'b00, 32'hCAFE_F00D, 52);
    mb.k = edge_cnt;
    expb_q.push_back(mb);
    @(negedge clk);
    bus_b.req = 1'b0;
    drain(1'b1, 100);

    repeat (3) @(negedge clk);
    chk("ram_q_leftover", ram_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
